// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2, used to size the digit counter.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-wide slice of the carry chain: sum, carry out, and the carry
// into the slice MSB (needed for signed overflow on the final digit).
module addsub_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] sum_w;

   // Plain ripple add of the digit with carry-in.
   always_comb begin
      sum_w = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
   end

   assign s    = sum_w[DIGIT-1:0];
   assign cout = sum_w[DIGIT];
   // The MSB sum bit is x^y^carry_in, so the incoming carry is recovered
   // without slicing below the MSB (works for DIGIT == 1 as well).
   assign cmsb = x[DIGIT-1] ^ y[DIGIT-1] ^ sum_w[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands are consumed DIGIT bits
// per clock through one shared addsub_digit slice, LSB digit first.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             ovf
);

   localparam int ND = WIDTH / DIGIT;
   localparam int CW = (ND > 1) ? clog2(ND) : 1;

   generate
      if (WIDTH % DIGIT != 0) begin : g_width_check
         $error("addsub_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] y_q;
   logic             carry_q;
   logic             ovf_q;

   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] opa_d;
   logic [WIDTH-1:0] opb_d;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] s_ext;

   logic [DIGIT-1:0] s_w;
   logic             cout_w;
   logic             cmsb_w;
   logic             accept_w;
   logic             last_w;

   addsub_digit #(
      .DIGIT(DIGIT)
   ) u_digit (
      .x    (opa_q[DIGIT-1:0]),
      .y    (opb_q[DIGIT-1:0]),
      .cin  (c_q),
      .s    (s_w),
      .cout (cout_w),
      .cmsb (cmsb_w)
   );

   assign accept_w = (state_q == IDLE) && in_valid && in_ready_q;
   assign last_w   = (cnt_q == CW'(ND - 1));

   // Next shift-register contents: operands move down one digit, the new
   // sum digit enters the result from the top.
   always_comb begin
      s_ext             = '0;
      s_ext[DIGIT-1:0]  = s_w;
      opa_d             = opa_q >> DIGIT;
      opb_d             = opb_q >> DIGIT;
      res_d             = (res_q >> DIGIT) | (s_ext << (WIDTH - DIGIT));
   end

   // Operand and partial-result shifters; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (accept_w) begin
         opa_q <= a;
         opb_q <= sub ? ~b : b;
      end else if (state_q == BUSY) begin
         opa_q <= opa_d;
         opb_q <= opb_d;
         res_q <= res_d;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         c_q         <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_w) begin
                  c_q        <= sub;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               c_q   <= cout_w;
               cnt_q <= cnt_q + 1'b1;
               if (last_w) begin
                  y_q         <= res_d;
                  carry_q     <= cout_w;
                  ovf_q       <= cmsb_w ^ cout_w;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial across several WIDTH/DIGIT configurations.
module tb_addsub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_s;
   logic [31:0] b_s;
   logic        sub_s;
   logic [5:0]  iv;
   logic [5:0]  ordy;
   logic [5:0]  ir;
   logic [5:0]  ov;
   logic [5:0]  cy;
   logic [5:0]  of;
   logic [7:0]  y0, y1, y2, y5;
   logic [15:0] y4;
   logic [31:0] y3;
   logic [31:0] yv [6];

   // Instance table: 0:8/2 1:8/4 2:8/1 3:32/8 4:16/4 5:8/8
   int W_T [6] = '{8, 8, 8, 32, 16, 8};
   int D_T [6] = '{2, 4, 1, 8, 4, 8};

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign yv[0] = {24'd0, y0};
   assign yv[1] = {24'd0, y1};
   assign yv[2] = {24'd0, y2};
   assign yv[3] = y3;
   assign yv[4] = {16'd0, y4};
   assign yv[5] = {24'd0, y5};

   addsub_serial #(.WIDTH(8), .DIGIT(2)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[7:0]), .b(b_s[7:0]),
      .sub(sub_s), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y0), .carry(cy[0]), .ovf(of[0]));
   addsub_serial #(.WIDTH(8), .DIGIT(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[7:0]), .b(b_s[7:0]),
      .sub(sub_s), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y1), .carry(cy[1]), .ovf(of[1]));
   addsub_serial #(.WIDTH(8), .DIGIT(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[7:0]), .b(b_s[7:0]),
      .sub(sub_s), .out_valid(ov[2]), .out_ready(ordy[2]), .y(y2), .carry(cy[2]), .ovf(of[2]));
   addsub_serial #(.WIDTH(32), .DIGIT(8)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_s), .b(b_s),
      .sub(sub_s), .out_valid(ov[3]), .out_ready(ordy[3]), .y(y3), .carry(cy[3]), .ovf(of[3]));
   addsub_serial #(.WIDTH(16), .DIGIT(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .a(a_s[15:0]), .b(b_s[15:0]),
      .sub(sub_s), .out_valid(ov[4]), .out_ready(ordy[4]), .y(y4), .carry(cy[4]), .ovf(of[4]));
   addsub_serial #(.WIDTH(8), .DIGIT(8)) u5 (
      .clk(clk), .rst(rst), .in_valid(iv[5]), .in_ready(ir[5]), .a(a_s[7:0]), .b(b_s[7:0]),
      .sub(sub_s), .out_valid(ov[5]), .out_ready(ordy[5]), .y(y5), .carry(cy[5]), .ovf(of[5]));

   // Reference: full-width unsigned result, carry/no-borrow from magnitude
   // comparison, overflow from the exact signed result leaving the range.
   function automatic void ref_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, output logic [31:0] ry, output logic rc,
                                  output logic ro);
      longint unsigned m, au, bu, r;
      longint sa, sb, sr, lim;
      m   = (64'd1 << w) - 64'd1;
      au  = {32'd0, av} & m;
      bu  = {32'd0, bv} & m;
      lim = longint'(64'd1 << (w - 1));
      sa  = (au >= 64'(lim)) ? longint'(au) - 2 * lim : longint'(au);
      sb  = (bu >= 64'(lim)) ? longint'(bu) - 2 * lim : longint'(bu);
      if (sv) begin
         r  = (au - bu) & m;
         rc = (au >= bu);
         sr = sa - sb;
      end else begin
         r  = (au + bu) & m;
         rc = ((au + bu) > m);
         sr = sa + sb;
      end
      ry = r[31:0];
      ro = (sr >= lim) || (sr < -lim);
   endfunction

   // Issue one operation on instance k and wait (bounded) for its result.
   task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input bit scramble, output logic [31:0] ry,
                         output logic rc, output logic ro, output int lat);
      int guard;
      @(negedge clk);
      a_s = av; b_s = bv; sub_s = sv; iv[k] = 1'b1;
      guard = 0;
      while (ir[k] !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk); #1;
      iv[k] = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         if (scramble) begin
            a_s = $urandom; b_s = $urandom; sub_s = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         if (ov[k] === 1'b1) begin
            lat = i;
            break;
         end
      end
      ry = yv[k]; rc = cy[k]; ro = of[k];
   endtask

   task automatic test_reset();
      rst = 1'b1; iv = '0; ordy = '1; a_s = '0; b_s = '0; sub_s = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
         n_total++;
         if (ir[k] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]);
         else n_pass++;
         n_total++;
         if (ov[k] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]);
         else n_pass++;
         n_total++;
         if ({yv[k], cy[k], of[k]} !== 34'd0)
            $display("FAIL reset_outputs[%0d]: got y=%0h c=%b o=%b want 0", k, yv[k], cy[k], of[k]);
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_basic();
      @(negedge clk);
      a_s = 32'd5; b_s = 32'd5; sub_s = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (ir[0] !== 1'b0) $display("FAIL busy_in_ready cycle %0d: got %b want 0", i, ir[0]);
         else n_pass++;
         n_total++;
         if (ov[0] !== 1'b0) $display("FAIL busy_out_valid cycle %0d: got %b want 0", i, ov[0]);
         else n_pass++;
         @(posedge clk); #1;
      end
      n_total++;
      if (ov[0] !== 1'b1) $display("FAIL add_latency: out_valid got %b want 1", ov[0]);
      else n_pass++;
      n_total++;
      if (yv[0] !== 32'd10 || cy[0] !== 1'b0 || of[0] !== 1'b0)
         $display("FAIL add_5_5: got y=%0h c=%b o=%b want y=a c=0 o=0", yv[0], cy[0], of[0]);
      else n_pass++;
   endtask

   task automatic test_sub();
      logic [31:0] ry; logic rc, ro; int lat;
      run_op(0, 32'd8, 32'd5, 1'b1, 1'b0, ry, rc, ro, lat);
      n_total++;
      if (ry !== 32'd3 || rc !== 1'b1 || ro !== 1'b0 || lat != 4)
         $display("FAIL sub_8_5: got y=%0h c=%b o=%b lat=%0d want y=3 c=1 o=0 lat=4", ry, rc, ro, lat);
      else n_pass++;
      run_op(0, 32'd5, 32'd8, 1'b1, 1'b0, ry, rc, ro, lat);
      n_total++;
      if (ry !== 32'hFD || rc !== 1'b0 || ro !== 1'b0 || lat != 4)
         $display("FAIL sub_5_8: got y=%0h c=%b o=%b lat=%0d want y=fd c=0 o=0 lat=4", ry, rc, ro, lat);
      else n_pass++;
   endtask

   task automatic test_ovf();
      logic [31:0] ry; logic rc, ro; int lat;
      run_op(1, 32'd127, 32'd1, 1'b0, 1'b0, ry, rc, ro, lat);
      n_total++;
      if (ry !== 32'h80 || rc !== 1'b0 || ro !== 1'b1 || lat != 2)
         $display("FAIL ovf_add: got y=%0h c=%b o=%b lat=%0d want y=80 c=0 o=1 lat=2", ry, rc, ro, lat);
      else n_pass++;
      run_op(1, 32'h80, 32'd1, 1'b1, 1'b0, ry, rc, ro, lat);
      n_total++;
      if (ry !== 32'd127 || rc !== 1'b1 || ro !== 1'b1 || lat != 2)
         $display("FAIL ovf_sub: got y=%0h c=%b o=%b lat=%0d want y=7f c=1 o=1 lat=2", ry, rc, ro, lat);
      else n_pass++;
   endtask

   task automatic test_hold();
      logic [31:0] ry; logic rc, ro; int lat;
      ordy[3] = 1'b0;
      run_op(3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, ry, rc, ro, lat);
      n_total++;
      if (ry !== 32'd0 || rc !== 1'b1 || ro !== 1'b0 || lat != 4)
         $display("FAIL wrap_32: got y=%0h c=%b o=%b lat=%0d want y=0 c=1 o=0 lat=4", ry, rc, ro, lat);
      else n_pass++;
      // A new request presented while the result is held must be ignored.
      @(negedge clk);
      a_s = 32'h1234_5678; b_s = 32'h1111_1111; iv[3] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_total++;
         if (ov[3] !== 1'b1 || y3 !== 32'd0 || ir[3] !== 1'b0)
            $display("FAIL hold cycle %0d: got ov=%b y=%0h ir=%b want ov=1 y=0 ir=0", i, ov[3], y3, ir[3]);
         else n_pass++;
      end
      @(negedge clk);
      iv[3] = 1'b0; ordy[3] = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (ov[3] !== 1'b0 || ir[3] !== 1'b1 || y3 !== 32'd0)
         $display("FAIL hold_release: got ov=%b ir=%b y=%0h want ov=0 ir=1 y=0", ov[3], ir[3], y3);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] ry; logic rc, ro; int lat;
      run_op(4, 32'h1234, 32'h1111, 1'b0, 1'b0, ry, rc, ro, lat);
      n_total++;
      if (ry !== 32'h2345 || rc !== 1'b0 || ro !== 1'b0 || lat != 4)
         $display("FAIL pre_reset_op: got y=%0h c=%b o=%b lat=%0d want y=2345 c=0 o=0 lat=4", ry, rc, ro, lat);
      else n_pass++;
      @(negedge clk);
      a_s = 32'h7777; b_s = 32'h0001; sub_s = 1'b0; iv[4] = 1'b1;
      for (int g = 0; g < 10 && ir[4] !== 1'b1; g++) @(negedge clk);
      @(posedge clk); #1;
      iv[4] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if (ov[4] !== 1'b0 || ir[4] !== 1'b1 || y4 !== 16'd0)
         $display("FAIL async_reset: got ov=%b ir=%b y=%0h want ov=0 ir=1 y=0", ov[4], ir[4], y4);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (ov[4] !== 1'b0) $display("FAIL reset_no_pulse: got ov=%b want 0", ov[4]);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_change_inputs();
      logic [31:0] ry, ey; logic rc, ro, ec, eo; int lat;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] av, bv; logic sv;
         av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
         ref_op(16, av, bv, sv, ey, ec, eo);
         run_op(4, av, bv, sv, 1'b1, ry, rc, ro, lat);
         n_total++;
         if (ry !== ey || rc !== ec || ro !== eo || lat != 4)
            $display("FAIL inputs_changed %0d: got y=%0h c=%b o=%b lat=%0d want y=%0h c=%b o=%b lat=4",
                     i, ry, rc, ro, lat, ey, ec, eo);
         else n_pass++;
      end
      @(negedge clk);
      sub_s = 1'b0;
   endtask

   task automatic test_back_to_back();
      int nout;
      repeat (3) @(negedge clk);
      a_s = 32'd20; b_s = 32'd3; sub_s = 1'b1; iv[0] = 1'b1;
      @(posedge clk);
      nout = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (ov[0] === 1'b1) nout++;
      end
      iv[0] = 1'b0;
      n_total++;
      if (nout != 10) $display("FAIL back_to_back: got %0d results want 10", nout);
      else n_pass++;
      repeat (10) @(posedge clk);
      #1;
      n_total++;
      if (y0 !== 8'd17 || cy[0] !== 1'b1) $display("FAIL back_to_back_value: got y=%0h c=%b want y=11 c=1", y0, cy[0]);
      else n_pass++;
   endtask

   task automatic test_random();
      int ks [4] = '{2, 5, 4, 3};
      logic [31:0] av, bv, ry, ey; logic sv, rc, ro, ec, eo; int lat;
      for (int j = 0; j < 4; j++) begin
         int k;
         k = ks[j];
         for (int i = 0; i < 1000; i++) begin
            av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
               0: av = 32'hFFFF_FFFF;
               1: av = 32'd1 << (W_T[k] - 1);
               2: bv = (32'd1 << (W_T[k] - 1)) - 32'd1;
               3: bv = av;
               default: ;
            endcase
            ref_op(W_T[k], av, bv, sv, ey, ec, eo);
            run_op(k, av, bv, sv, 1'b0, ry, rc, ro, lat);
            n_total++;
            if (ry !== ey) $display("FAIL rand_y w%0d/d%0d: got %0h want %0h", W_T[k], D_T[k], ry, ey);
            else n_pass++;
            n_total++;
            if (rc !== ec) $display("FAIL rand_carry w%0d/d%0d: got %b want %b", W_T[k], D_T[k], rc, ec);
            else n_pass++;
            n_total++;
            if (ro !== eo) $display("FAIL rand_ovf w%0d/d%0d: got %b want %b", W_T[k], D_T[k], ro, eo);
            else n_pass++;
            n_total++;
            if (lat != W_T[k] / D_T[k])
               $display("FAIL rand_latency w%0d/d%0d: got %0d want %0d", W_T[k], D_T[k], lat, W_T[k] / D_T[k]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; iv = '0; ordy = '1; a_s = '0; b_s = '0; sub_s = 1'b0;
      test_reset();
      test_add_basic();
      test_sub();
      test_ovf();
      test_hold();
      test_reset_mid();
      test_change_inputs();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
